// File: rtl/riscv_alu_issue.sv
// rtl/riscv_alu_issue.sv - RV32I OP/OP-IMM/LUI decode/issue stage with ID/EX register and register file
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   instr_valid_i     instruction offered on instr_i
//   instr_i           32-bit RV32I instruction word
//   instr_ready_o     instruction taken when instr_valid_i && instr_ready_o at the edge
//   stall_i           downstream hold: freezes the ID/EX register and blocks retire
//   opr_a_o/opr_b_o   registered operands to the execute ALU
//   op_sel_o          registered ALU op select (riscv_pkg OP_* encoding)
//   ex_res_i          combinational ALU result for the current operands/op
//   retire_o          high in the cycle the EX instruction writes back
//   illegal_o         one-cycle pulse after an undecodable instruction is taken
//   dbg_addr_i        debug register-file read address
//   dbg_data_o        debug register-file read data (x0 reads 0)

package riscv_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_LSR = 4'd3;
  localparam logic [3:0] OP_ASR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_ULT = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_AND = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
endpackage

module riscv_alu_issue
  import riscv_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  input  logic        stall_i,
  output logic [31:0] opr_a_o,
  output logic [31:0] opr_b_o,
  output logic [3:0]  op_sel_o,
  input  logic [31:0] ex_res_i,
  output logic        retire_o,
  output logic        illegal_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
);

  logic [31:0] regs [32];

  logic        ex_valid;
  logic        ex_wr;
  logic [4:0]  ex_rd;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'h000};

  // A source matches the in-flight writer; x0 never matches because writes to it are dropped.
  logic fwd1;
  logic fwd2;
  logic use_rs1;
  logic use_rs2;
  logic hazard_stall;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign fwd1    = ex_valid && ex_wr && (ex_rd == rs1) && (rs1 != 5'd0);
  assign fwd2    = ex_valid && ex_wr && (ex_rd == rs2) && (rs2 != 5'd0);
  assign use_rs1 = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
  assign use_rs2 = (opcode == OPC_OP);

  assign rs1_val = (BYPASS_EN && fwd1) ? ex_res_i : ((rs1 == 5'd0) ? 32'h0 : regs[rs1]);
  assign rs2_val = (BYPASS_EN && fwd2) ? ex_res_i : ((rs2 == 5'd0) ? 32'h0 : regs[rs2]);

  assign hazard_stall = !BYPASS_EN && instr_valid_i &&
                        ((use_rs1 && fwd1) || (use_rs2 && fwd2));

  logic accept;
  logic retire;

  assign instr_ready_o = !(ex_valid && stall_i) && !hazard_stall;
  assign accept        = instr_valid_i && instr_ready_o;
  assign retire        = ex_valid && !stall_i;
  assign retire_o      = retire;
  assign dbg_data_o    = (dbg_addr_i == 5'd0) ? 32'h0 : regs[dbg_addr_i];

  logic        dec_legal;
  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_a     = 32'h0;
    dec_b     = 32'h0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              dec_op    = OP_ADD;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              dec_op    = OP_SUB;
            end
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              dec_op    = OP_LSR;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              dec_op    = OP_ASR;
            end
          end
          default: begin
            dec_legal = (funct7 == 7'b0000000);
            case (funct3)
              3'b001:  dec_op = OP_SLL;
              3'b010:  dec_op = OP_SLT;
              3'b011:  dec_op = OP_ULT;
              3'b100:  dec_op = OP_XOR;
              3'b110:  dec_op = OP_OR;
              default: dec_op = OP_AND;
            endcase
          end
        endcase
      end
      OPC_OP_IMM: begin
        dec_a = rs1_val;
        dec_b = imm_i;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT; end
          3'b011: begin dec_legal = 1'b1; dec_op = OP_ULT; end
          3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
          3'b001: begin
            dec_legal = (funct7 == 7'b0000000);
            dec_op    = OP_SLL;
          end
          default: begin
            if (funct7 == 7'b0000000) begin
              dec_legal = 1'b1;
              dec_op    = OP_LSR;
            end else if (funct7 == 7'b0100000) begin
              dec_legal = 1'b1;
              dec_op    = OP_ASR;
            end
          end
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        dec_a     = 32'h0;
        dec_b     = imm_u;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    // Undecodable words still occupy EX as a harmless no-write bubble.
    if (!dec_legal) begin
      dec_op = OP_ADD;
      dec_a  = 32'h0;
      dec_b  = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_rd     <= 5'd0;
      opr_a_o   <= 32'h0;
      opr_b_o   <= 32'h0;
      op_sel_o  <= OP_ADD;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= accept && !dec_legal;
      if (accept) begin
        ex_valid <= 1'b1;
        ex_wr    <= dec_legal;
        ex_rd    <= rd;
        opr_a_o  <= dec_a;
        opr_b_o  <= dec_b;
        op_sel_o <= dec_op;
      end else if (retire) begin
        ex_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (retire && ex_wr && (ex_rd != 5'd0)) begin
      regs[ex_rd] <= ex_res_i;
    end
  end

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb/tb_riscv_alu_issue.sv - randomized, model-checked bench for riscv_alu_issue (bypass and stall variants)

module tb_riscv_alu_issue;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Index 0: BYPASS_EN=1, index 1: BYPASS_EN=0
  logic        instr_valid [2];
  logic [31:0] instr       [2];
  logic        ready       [2];
  logic        stall       [2];
  logic [31:0] opr_a       [2];
  logic [31:0] opr_b       [2];
  logic [3:0]  op_sel      [2];
  logic [31:0] ex_res      [2];
  logic        retire      [2];
  logic        illegal     [2];
  logic [4:0]  dbg_addr    [2];
  logic [31:0] dbg_data    [2];

  riscv_alu_issue #(.BYPASS_EN(1'b1)) u_byp (
    .clk(clk), .reset(reset),
    .instr_valid_i(instr_valid[0]), .instr_i(instr[0]), .instr_ready_o(ready[0]),
    .stall_i(stall[0]), .opr_a_o(opr_a[0]), .opr_b_o(opr_b[0]), .op_sel_o(op_sel[0]),
    .ex_res_i(ex_res[0]), .retire_o(retire[0]), .illegal_o(illegal[0]),
    .dbg_addr_i(dbg_addr[0]), .dbg_data_o(dbg_data[0])
  );

  riscv_alu_issue #(.BYPASS_EN(1'b0)) u_nobyp (
    .clk(clk), .reset(reset),
    .instr_valid_i(instr_valid[1]), .instr_i(instr[1]), .instr_ready_o(ready[1]),
    .stall_i(stall[1]), .opr_a_o(opr_a[1]), .opr_b_o(opr_b[1]), .op_sel_o(op_sel[1]),
    .ex_res_i(ex_res[1]), .retire_o(retire[1]), .illegal_o(illegal[1]),
    .dbg_addr_i(dbg_addr[1]), .dbg_data_o(dbg_data[1])
  );

  // Execute unit stand-in
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_LSR:  return a >> b[4:0];
      OP_ASR:  return 32'($signed(a) >>> b[4:0]);
      OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
      OP_ULT:  return {31'b0, a < b};
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 32'h0;
    endcase
  endfunction

  assign ex_res[0] = alu(opr_a[0], opr_b[0], op_sel[0]);
  assign ex_res[1] = alu(opr_a[1], opr_b[1], op_sel[1]);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: result of instruction by funct3 and the alternate (SUB/SRA) bit
  function automatic logic [31:0] sem(input logic [2:0] f3, input logic alt, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [3:0] op_of(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{OP_ADD, OP_SLL, OP_SLT, OP_ULT, OP_XOR, OP_LSR, OP_OR, OP_AND};
    if (alt && f3 == 3'd0) return OP_SUB;
    if (alt && f3 == 3'd5) return OP_ASR;
    return tbl[f3];
  endfunction

  typedef struct packed {
    logic        legal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } dec_t;

  function automatic dec_t model_dec(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2);
    dec_t r;
    logic [6:0] f7;
    logic [2:0] f3;
    logic alt;
    f7 = ins[31:25];
    f3 = ins[14:12];
    alt = 1'b0;
    r = '0;
    r.op = OP_ADD;
    case (ins[6:0])
      OPC_OP: begin
        r.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        alt = f7[5];
        r.a = v1;
        r.b = v2;
      end
      OPC_OP_IMM: begin
        r.legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        alt = (f3 == 3'd5) && f7[5];
        r.a = v1;
        r.b = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LUI: begin
        r.legal = 1'b1;
        f3 = 3'd0;
        r.a = 32'h0;
        r.b = {ins[31:12], 12'h000};
      end
      default: r.legal = 1'b0;
    endcase
    if (r.legal) begin
      r.op  = op_of(f3, alt);
      r.res = sem(f3, alt, r.a, r.b);
    end else begin
      r.a = 32'h0;
      r.b = 32'h0;
    end
    return r;
  endfunction

  // Model state: what the EX slot and register file must hold
  logic        m_ev   [2];
  logic        m_wr   [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] m_res  [2];
  logic [3:0]  m_op   [2];
  logic        m_ill  [2];
  logic [31:0] m_regs [2][32];

  int retire_cnt [2];
  int run        [2];
  int max_run    [2];
  int ready_low  [2];
  int ill_cnt    [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic haz, exp_ready, exp_retire, acc;
      logic [4:0] s1, s2;
      dec_t dd;
      if (reset) begin
        m_ev[d] = 1'b0; m_wr[d] = 1'b0; m_rd[d] = 5'd0;
        m_a[d] = 32'h0; m_b[d] = 32'h0; m_res[d] = 32'h0;
        m_op[d] = OP_ADD; m_ill[d] = 1'b0;
        for (int r = 0; r < 32; r++) m_regs[d][r] = 32'h0;
      end
      s1 = instr[d][19:15];
      s2 = instr[d][24:20];
      haz = 1'b0;
      if (d == 1 && instr_valid[d] && m_ev[d] && m_wr[d] && m_rd[d] != 5'd0) begin
        haz = (((instr[d][6:0] == OPC_OP) || (instr[d][6:0] == OPC_OP_IMM)) && s1 == m_rd[d]) ||
              ((instr[d][6:0] == OPC_OP) && s2 == m_rd[d]);
      end
      exp_ready  = !(m_ev[d] && stall[d]) && !haz;
      exp_retire = m_ev[d] && !stall[d];

      chk($sformatf("ready[%0d]", d),   32'(ready[d]),   32'(exp_ready));
      chk($sformatf("retire[%0d]", d),  32'(retire[d]),  32'(exp_retire));
      chk($sformatf("illegal[%0d]", d), 32'(illegal[d]), 32'(m_ill[d]));
      chk($sformatf("opr_a[%0d]", d),   opr_a[d],        m_a[d]);
      chk($sformatf("opr_b[%0d]", d),   opr_b[d],        m_b[d]);
      chk($sformatf("op_sel[%0d]", d),  32'(op_sel[d]),  32'(m_op[d]));
      chk($sformatf("dbg[%0d] x%0d", d, dbg_addr[d]), dbg_data[d], m_regs[d][dbg_addr[d]]);

      if (retire[d]) begin
        retire_cnt[d]++;
        run[d]++;
        if (run[d] > max_run[d]) max_run[d] = run[d];
      end else begin
        run[d] = 0;
      end
      if (instr_valid[d] && !ready[d]) ready_low[d]++;
      if (illegal[d]) ill_cnt[d]++;

      if (!reset) begin
        acc = instr_valid[d] && exp_ready;
        if (exp_retire && m_wr[d] && m_rd[d] != 5'd0) m_regs[d][m_rd[d]] = m_res[d];
        m_ill[d] = 1'b0;
        if (acc) begin
          dd = model_dec(instr[d], m_regs[d][s1], m_regs[d][s2]);
          m_ev[d]  = 1'b1;
          m_wr[d]  = dd.legal;
          m_rd[d]  = instr[d][11:7];
          m_a[d]   = dd.a;
          m_b[d]   = dd.b;
          m_op[d]  = dd.op;
          m_res[d] = dd.res;
          m_ill[d] = !dd.legal;
        end else if (exp_retire) begin
          m_ev[d] = 1'b0;
        end
      end
    end
  end

  int rnd_d = -1;

  always @(posedge clk) begin
    #1;
    if (rnd_d >= 0) begin
      stall[rnd_d]    = ($urandom_range(0, 4) == 0);
      dbg_addr[rnd_d] = 5'($urandom);
    end
  end

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    k   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    f7  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
    imm = 12'($urandom);
    if (k <= 3) return r_type(f7, rs2, rs1, f3, rd);
    if (k <= 7) begin
      if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
      return i_type(imm, rs1, f3, rd);
    end
    if (k == 8) return {20'($urandom), rd, OPC_LUI};
    return $urandom;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [31:0] ins);
    int tries;
    logic acc;
    instr_valid[d] = 1'b1;
    instr[d] = ins;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 40) begin
      @(negedge clk);
      acc = ready[d];
      @(posedge clk);
      #1;
      tries++;
    end
    instr_valid[d] = 1'b0;
    instr[d] = $urandom;
    chk($sformatf("accept[%0d] %h", d, ins), 32'(acc), 32'd1);
  endtask

  task automatic check_reg(input int d, input logic [4:0] a, input logic [31:0] exp);
    @(posedge clk);
    #1;
    dbg_addr[d] = a;
    #2;
    chk($sformatf("reg[%0d] x%0d", d, a), dbg_data[d], exp);
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      instr_valid[d] = 1'b0;
      instr[d]       = 32'h0;
      stall[d]       = 1'b0;
      dbg_addr[d]    = 5'd0;
      retire_cnt[d]  = 0;
      run[d]         = 0;
      max_run[d]     = 0;
      ready_low[d]   = 0;
      ill_cnt[d]     = 0;
    end
    #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      chk($sformatf("rst opr_a[%0d]", d), opr_a[d], 32'h0);
      chk($sformatf("rst opr_b[%0d]", d), opr_b[d], 32'h0);
      chk($sformatf("rst op_sel[%0d]", d), 32'(op_sel[d]), 32'(OP_ADD));
      chk($sformatf("rst retire[%0d]", d), 32'(retire[d]), 32'd0);
      chk($sformatf("rst illegal[%0d]", d), 32'(illegal[d]), 32'd0);

      // Back-to-back ADDIs retire on consecutive cycles
      retire_cnt[d] = 0;
      max_run[d] = 0;
      send(d, i_type(12'd5, 5'd0, 3'd0, 5'd1));
      send(d, i_type(12'hFFD, 5'd0, 3'd0, 5'd2));
      idle(3);
      chk($sformatf("b2b retires[%0d]", d), 32'(retire_cnt[d]), 32'd2);
      chk($sformatf("b2b run[%0d]", d), 32'(max_run[d]), 32'd2);
      check_reg(d, 5'd1, 32'd5);
      check_reg(d, 5'd2, 32'hFFFF_FFFD);

      // Dependent ADD: bypass has no bubble, stall variant loses exactly one cycle
      ready_low[d] = 0;
      send(d, i_type(12'd7, 5'd0, 3'd0, 5'd1));
      send(d, r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd3));
      chk($sformatf("raw opr_a[%0d]", d), opr_a[d], 32'd7);
      chk($sformatf("raw opr_b[%0d]", d), opr_b[d], 32'd7);
      chk($sformatf("raw ready_low[%0d]", d), 32'(ready_low[d]), (d == 1) ? 32'd1 : 32'd0);
      idle(2);
      check_reg(d, 5'd3, 32'd14);

      send(d, i_type(12'h401, 5'd2, 3'd5, 5'd4));
      send(d, r_type(7'h00, 5'd2, 5'd0, 3'd3, 5'd5));
      send(d, {20'hABCDE, 5'd6, OPC_LUI});
      idle(2);
      check_reg(d, 5'd4, 32'hFFFF_FFFE);
      check_reg(d, 5'd5, 32'd1);
      check_reg(d, 5'd6, 32'hABCD_E000);

      // Bad opcode, then a write to x0
      ill_cnt[d] = 0;
      send(d, 32'h0000_007F);
      send(d, r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd0));
      idle(3);
      chk($sformatf("illegal pulses[%0d]", d), 32'(ill_cnt[d]), 32'd1);
      check_reg(d, 5'd0, 32'h0);
      check_reg(d, 5'd1, 32'd7);

      // Randomized traffic with random stalls
      rnd_d = d;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(d, rand_instr());
      end
      rnd_d = -1;
      stall[d] = 1'b0;
      idle(3);

      // Stall with an instruction in EX, then reset in the middle of the stall
      send(d, i_type(12'd9, 5'd0, 3'd0, 5'd7));
      stall[d] = 1'b1;
      retire_cnt[d] = 0;
      idle(3);
      chk($sformatf("stall retires[%0d]", d), 32'(retire_cnt[d]), 32'd0);
      chk($sformatf("stall opr_b[%0d]", d), opr_b[d], 32'd9);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      stall[d] = 1'b0;
      chk($sformatf("post-rst op_sel[%0d]", d), 32'(op_sel[d]), 32'(OP_ADD));
      for (int r = 0; r < 32; r++) check_reg(d, 5'(r), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu_issue.md
Name: riscv_alu_issue

Overview:
- Single-issue decode/issue stage that produces the operand/op-select interface consumed by the combinational execute ALU, and retires the ALU result back into an internal RV32I register file.
- Accepts 32-bit instructions over a valid/ready handshake and decodes OP, OP-IMM and LUI.
- Holds one instruction in an ID/EX register that drives the execute unit, then writes `ex_res_i` to rd on retire.
- Resolves read-after-write hazards through a bypass path, or by stalling when the bypass is disabled.

Parameters:
- BYPASS_EN, 1: 1 = forward `ex_res_i` to a dependent decode; 0 = deassert `instr_ready_o` on a RAW hazard instead.

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid_i  input  1  instruction offered
- instr_i  input  32  RV32I instruction word
- instr_ready_o  output  1  instruction accepted when valid&ready at clk edge
- stall_i  input  1  downstream hold; freezes the ID/EX register, blocks retire
- opr_a_o  output  32  operand A to execute (registered)
- opr_b_o  output  32  operand B to execute (registered)
- op_sel_o  output  4  ALU op select, riscv_pkg OP_* encoding (registered)
- ex_res_i  input  32  combinational result returned by execute for current opr_a_o/opr_b_o/op_sel_o
- retire_o  output  1  combinational; high in cycle an instruction writes back
- illegal_o  output  1  registered 1-cycle pulse: accepted instruction was not decodable
- dbg_addr_i  input  5  debug register-file read address
- dbg_data_o  output  32  combinational regfile read; x0 reads 0

Behaviour:
- Reset (async, active-high):
  - ex_valid=0; opr_a_o=opr_b_o=0; op_sel_o=OP_ADD; illegal_o=0.
  - All 31 writable registers cleared to 0; x0 is hardwired 0.
  - Reset mid-operation drops the in-flight instruction with no writeback.
- ID/EX register fields: ex_valid, ex_rd[4:0], ex_wr, plus the operands and op_sel.
- Ready: `instr_ready_o = !(ex_valid && stall_i) && !hazard_stall`. hazard_stall is always 0 when BYPASS_EN=1.
- Retire: `retire_o = ex_valid && !stall_i`. On that edge, if ex_wr and ex_rd!=0, `regfile[ex_rd] <= ex_res_i`. Latency from accept to retire is exactly 1 cycle when stall_i is low.
- Accept edge: the ID/EX register loads the decoded instruction and ex_valid=1. If no accept but retire, ex_valid<=0. If stalled, everything holds.
- Decode, opcode 0110011 (OP), funct7/funct3:
  - 0000000/000 ADD->OP_ADD; 0100000/000 SUB->OP_SUB
  - 001 SLL->OP_SLL; 101 SRL->OP_LSR; 0100000/101 SRA->OP_ASR
  - 010 SLT->OP_SLT; 011 SLTU->OP_ULT
  - 100 XOR->OP_XOR; 110 OR->OP_OR; 111 AND->OP_AND
  - any other funct7 is illegal.
- Decode, opcode 0010011 (OP-IMM): opr_b = sign-extended instr[31:20].
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI map as their OP counterparts.
  - SLLI needs instr[31:25]=0000000; SRLI needs 0000000; SRAI needs 0100000. Otherwise illegal.
  - SLTIU compares against the sign-extended immediate treated as unsigned.
- Decode, opcode 0110111 (LUI): opr_a=0, opr_b={instr[31:12],12'h0}, OP_ADD.
- Illegal instruction (any other opcode, or bad funct):
  - Still consumed: ready is honoured and accept occurs.
  - Loads ex_valid=1, ex_wr=0, operands 0, op_sel OP_ADD.
  - illegal_o pulses in the following cycle; it retires with no write.
- Operand read (rs1=instr[19:15], rs2=instr[24:20]): a read of x0 gives 0. When reading with ex_valid && ex_wr && ex_rd==rs && rs!=0:
  - BYPASS_EN=1: the operand takes ex_res_i.
  - BYPASS_EN=0: hazard_stall=1 and ready=0 until that instruction retires.
  - rs2 is only checked for OP; rs1 is not checked for LUI.
- Simultaneous events:
  - Retire and accept on the same edge is legal, giving back-to-back throughput of 1/cycle.
  - stall_i with ex_valid=0 does not block accept.
  - A write to x0 is discarded; writes to x0 never set the bypass.

Test Plan:
- Reset, then ADDI x1,x0,5 followed by ADDI x2,x0,-3 back-to-back -> retire_o high 2 consecutive cycles; dbg x1=5, x2=32'hFFFFFFFD.
- BYPASS_EN=1: ADDI x1,x0,7 then ADD x3,x1,x1 on the next cycle -> no bubble; opr_a_o=opr_b_o=7; x3=14.
- BYPASS_EN=0: same sequence -> instr_ready_o low exactly 1 cycle; final x3=14.
- SRAI x4,x2,1 (x2=0xFFFFFFFD) gives x4=0xFFFFFFFE; SLTU x5,x0,x2 gives x5=1; LUI x6,0xABCDE gives x6=0xABCDE000.
- Instruction 32'h0000007F (bad opcode), then ADD x0,x1,x1 -> illegal_o pulses once; no register changes; x0 still reads 0.
- Hold stall_i high 3 cycles with an instruction in EX, then assert reset mid-stall -> outputs held during stall, no retire; after reset, all dbg reads return 0 and op_sel_o=OP_ADD.
